// File: rtl/multi_issue_scoreboard.sv
// N-lane issue scoreboard: per-register pending-write countdowns select the issuable prefix
// of the decode bundle and steer the bypass muxes; issue/stall/fwd are combinational.
module multi_issue_scoreboard #(
  parameter int LANES  = 2,
  parameter int NREG   = 32,
  parameter int LAT_W  = 3,
  parameter int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int SCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        lane_valid_d,
  input  logic [LANES*5-1:0]      rs1_d,
  input  logic [LANES*5-1:0]      rs2_d,
  input  logic [LANES*5-1:0]      rd_d,
  input  logic [LANES-1:0]        regwrite_d,
  input  logic [LANES*LAT_W-1:0]  lat_d,
  input  logic [LANES-1:0]        use_rs1_d,
  input  logic [LANES-1:0]        use_rs2_d,
  input  logic                    flush,
  output logic [LANES-1:0]        issue,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic [LANES-1:0]        fwd_vld1,
  output logic [LANES-1:0]        fwd_vld2,
  output logic [LANES*LIDX_W-1:0] fwd_lane1,
  output logic [LANES*LIDX_W-1:0] fwd_lane2,
  output logic [SCNT_W-1:0]       stall_cycles
);

  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  logic [LAT_W-1:0]  cnt_q   [NREG];
  logic [LAT_W-1:0]  cnt_d   [NREG];
  logic [LIDX_W-1:0] plane_q [NREG];
  logic [LIDX_W-1:0] plane_d [NREG];
  logic [SCNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [4:0]       rs1     [LANES];
  logic [4:0]       rs2     [LANES];
  logic [4:0]       rd      [LANES];
  logic [LAT_W-1:0] lat_eff [LANES];
  logic [LANES-1:0] writes;
  logic [LANES-1:0] blocked;
  logic             chain;

  for (genvar g = 0; g < LANES; g++) begin : g_unpack
    assign rs1[g]     = rs1_d[g*5 +: 5];
    assign rs2[g]     = rs2_d[g*5 +: 5];
    assign rd[g]      = rd_d[g*5 +: 5];
    assign lat_eff[g] = (lat_d[g*LAT_W +: LAT_W] == '0) ? LAT_ONE : lat_d[g*LAT_W +: LAT_W];
    assign writes[g]  = regwrite_d[g] && (rd[g] != 5'd0);
  end

  // Hazard detection: no in-bundle bypass, so any older same-bundle writer of a source blocks.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (use_rs1_d[i] && rs1[i] != 5'd0 && cnt_q[rs1[i]] > LAT_ONE) blocked[i] = 1'b1;
      if (use_rs2_d[i] && rs2[i] != 5'd0 && cnt_q[rs2[i]] > LAT_ONE) blocked[i] = 1'b1;
      if (writes[i] && cnt_q[rd[i]] > lat_eff[i]) blocked[i] = 1'b1;
      for (int k = 0; k < i; k++) begin
        if (lane_valid_d[k] && writes[k]) begin
          if (use_rs1_d[i] && rs1[i] == rd[k]) blocked[i] = 1'b1;
          if (use_rs2_d[i] && rs2[i] == rd[k]) blocked[i] = 1'b1;
          if (writes[i] && rd[i] == rd[k] && lat_eff[k] > lat_eff[i]) blocked[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue = '0;
    chain = !flush;
    for (int i = 0; i < LANES; i++) begin
      issue[i] = chain && lane_valid_d[i] && !blocked[i];
      chain    = issue[i];
    end
  end

  assign stall_d      = (|(lane_valid_d & ~issue)) && !flush;
  assign stall_f      = stall_d;
  assign stall_cycles = stall_cycles_q;

  // Bypass steering only; deliberately not an input to issue.
  always_comb begin
    fwd_vld1  = '0;
    fwd_vld2  = '0;
    fwd_lane1 = '0;
    fwd_lane2 = '0;
    for (int i = 0; i < LANES; i++) begin
      if (use_rs1_d[i] && rs1[i] != 5'd0 && cnt_q[rs1[i]] == LAT_ONE) begin
        fwd_vld1[i]                   = 1'b1;
        fwd_lane1[i*LIDX_W +: LIDX_W] = plane_q[rs1[i]];
      end
      if (use_rs2_d[i] && rs2[i] != 5'd0 && cnt_q[rs2[i]] == LAT_ONE) begin
        fwd_vld2[i]                   = 1'b1;
        fwd_lane2[i*LIDX_W +: LIDX_W] = plane_q[rs2[i]];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]   = (cnt_q[r] != '0) ? cnt_q[r] - LAT_ONE : cnt_q[r];
      plane_d[r] = plane_q[r];
    end
    // Ascending lane order lets the youngest writer of a shared rd win.
    for (int i = 0; i < LANES; i++) begin
      if (issue[i] && writes[i]) begin
        cnt_d[rd[i]]   = lat_eff[i];
        plane_d[rd[i]] = LIDX_W'(i);
      end
    end
    stall_cycles_d = stall_cycles_q;
    if (stall_d && stall_cycles_q != {SCNT_W{1'b1}}) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]   <= '0;
        plane_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]   <= cnt_d[r];
        plane_q[r] <= plane_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_multi_issue_scoreboard.sv
// Scenario bench for multi_issue_scoreboard (2 lanes): per-cycle expectations are queued
// with the stimulus and popped against the sampled outputs on the falling edge.
module tb_multi_issue_scoreboard;

  logic        clk, rst_n;
  logic [1:0]  lane_valid_d, regwrite_d, use_rs1_d, use_rs2_d;
  logic [9:0]  rs1_d, rs2_d, rd_d;
  logic [5:0]  lat_d;
  logic        flush;
  logic [1:0]  issue, fwd_vld1, fwd_vld2, fwd_lane1, fwd_lane2;
  logic        stall_f, stall_d;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic v, rw, u1, u2;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] lat;
  } lane_t;

  typedef struct packed {
    logic [1:0] iss;
    logic       sd, sf;
    logic [1:0] fv1, fl1, fv2, fl2;
  } exp_t;

  typedef struct packed {
    lane_t l0, l1;
    logic  fl;
    exp_t  e;
  } cyc_t;

  localparam lane_t NOP = '0;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  int   exp_sc = 0;

  multi_issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .lane_valid_d(lane_valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .lat_d(lat_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .flush(flush), .issue(issue), .stall_f(stall_f), .stall_d(stall_d),
    .fwd_vld1(fwd_vld1), .fwd_vld2(fwd_vld2), .fwd_lane1(fwd_lane1), .fwd_lane2(fwd_lane2),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic lane_t ln(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] lat);
    lane_t l;
    l.v = 1'b1;  l.rw = (rd != 5'd0);  l.u1 = (rs1 != 5'd0);  l.u2 = (rs2 != 5'd0);
    l.rd = rd;   l.rs1 = rs1;          l.rs2 = rs2;           l.lat = lat;
    return l;
  endfunction

  function automatic exp_t ex(input logic [1:0] iss, input logic sd, input logic [1:0] fv1,
                              input logic [1:0] fl1, input logic [1:0] fv2, input logic [1:0] fl2);
    exp_t e;
    e.iss = iss; e.sd = sd; e.sf = sd; e.fv1 = fv1; e.fl1 = fl1; e.fv2 = fv2; e.fl2 = fl2;
    return e;
  endfunction

  function automatic cyc_t cy(input lane_t l0, input lane_t l1, input logic fl, input exp_t e);
    cyc_t c;
    c.l0 = l0; c.l1 = l1; c.fl = fl; c.e = e;
    return c;
  endfunction

  // Lane index fields only matter where the operand is actually bypassed.
  function automatic exp_t sample();
    exp_t o;
    o.iss = issue;    o.sd = stall_d;            o.sf = stall_f;
    o.fv1 = fwd_vld1; o.fl1 = fwd_lane1 & fwd_vld1;
    o.fv2 = fwd_vld2; o.fl2 = fwd_lane2 & fwd_vld2;
    return o;
  endfunction

  task automatic apply(input cyc_t c);
    lane_valid_d = {c.l1.v,   c.l0.v};
    regwrite_d   = {c.l1.rw,  c.l0.rw};
    use_rs1_d    = {c.l1.u1,  c.l0.u1};
    use_rs2_d    = {c.l1.u2,  c.l0.u2};
    rd_d         = {c.l1.rd,  c.l0.rd};
    rs1_d        = {c.l1.rs1, c.l0.rs1};
    rs2_d        = {c.l1.rs2, c.l0.rs2};
    lat_d        = {c.l1.lat, c.l0.lat};
    flush        = c.fl;
    q.push_back(c.e);
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n = 1'b0;
    lane_valid_d = '0; regwrite_d = '0; use_rs1_d = '0; use_rs2_d = '0;
    rd_d = '0; rs1_d = '0; rs2_d = '0; lat_d = '0; flush = 1'b0;
    @(negedge clk);
    o = sample();
    nchk++;
    if (o !== exp_t'(0)) begin nerr++; $display("FAIL reset_outputs: got %h want 0", o); end
    nchk++;
    if (stall_cycles !== 16'd0) begin nerr++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    cyc_t t [3];
    exp_t o, e;
    t = '{cy(ln(5, 0, 0, 2), NOP, 1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(6, 5, 1, 1), NOP, 1'b0, ex(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(6, 5, 1, 1), NOP, 1'b0, ex(2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00))};
    foreach (t[n]) begin
      apply(t[n]); @(negedge clk);
      o = sample(); e = q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL load_use[%0d]: got %h want %h", n, o, e); end
      if (e.sd) exp_sc++;
      @(posedge clk); #1;
    end
    nchk++;
    if (stall_cycles !== 16'(exp_sc)) begin nerr++; $display("FAIL load_use_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_same_bundle_raw();
    cyc_t t [2];
    exp_t o, e;
    t = '{cy(ln(3, 1, 0, 1), ln(4, 3, 2, 1), 1'b0, ex(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(4, 3, 2, 1), NOP,            1'b0, ex(2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00))};
    foreach (t[n]) begin
      apply(t[n]); @(negedge clk);
      o = sample(); e = q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL same_bundle_raw[%0d]: got %h want %h", n, o, e); end
      if (e.sd) exp_sc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_independent();
    cyc_t t [3];
    exp_t o, e;
    t = '{cy(ln(7, 0, 0, 1),  ln(8, 0, 0, 0),  1'b0, ex(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(10, 7, 0, 1), ln(11, 0, 8, 1), 1'b0, ex(2'b11, 1'b0, 2'b01, 2'b00, 2'b10, 2'b10)),
          cy(ln(0, 7, 0, 1),  ln(0, 8, 0, 1),  1'b0, ex(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00))};
    foreach (t[n]) begin
      apply(t[n]); @(negedge clk);
      o = sample(); e = q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL independent[%0d]: got %h want %h", n, o, e); end
      if (e.sd) exp_sc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_waw();
    cyc_t t [9];
    exp_t o, e;
    t = '{cy(ln(9, 0, 0, 3),  NOP,              1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(9, 1, 0, 1),  NOP,              1'b0, ex(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(9, 1, 0, 1),  NOP,              1'b0, ex(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(9, 1, 0, 1),  NOP,              1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 9, 0, 1),  NOP,              1'b0, ex(2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00)),
          cy(ln(12, 0, 0, 3), ln(12, 0, 0, 1),  1'b0, ex(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(13, 0, 0, 1), ln(13, 0, 0, 2),  1'b0, ex(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 13, 0, 1), NOP,              1'b0, ex(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 13, 0, 1), NOP,              1'b0, ex(2'b01, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00))};
    foreach (t[n]) begin
      apply(t[n]); @(negedge clk);
      o = sample(); e = q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL waw[%0d]: got %h want %h", n, o, e); end
      if (e.sd) exp_sc++;
      @(posedge clk); #1;
    end
    nchk++;
    if (stall_cycles !== 16'(exp_sc)) begin nerr++; $display("FAIL waw_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_flush();
    cyc_t t [6];
    exp_t o, e;
    t = '{cy(ln(5, 0, 0, 2),  NOP,             1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(14, 5, 0, 1), ln(15, 5, 0, 1), 1'b1, ex(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 14, 0, 1), ln(0, 5, 0, 1),  1'b0, ex(2'b11, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 5, 0, 1),  NOP,             1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(20, 0, 0, 1), NOP,             1'b1, ex(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)),
          cy(ln(0, 20, 0, 1), NOP,             1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00))};
    foreach (t[n]) begin
      apply(t[n]); @(negedge clk);
      o = sample(); e = q.pop_front(); nchk++;
      if (o !== e) begin nerr++; $display("FAIL flush[%0d]: got %h want %h", n, o, e); end
      if (e.sd) exp_sc++;
      @(posedge clk); #1;
    end
    nchk++;
    if (stall_cycles !== 16'(exp_sc)) begin nerr++; $display("FAIL flush_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  task automatic test_reset_midop();
    exp_t o, e;
    apply(cy(ln(16, 0, 0, 7), NOP, 1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)));
    @(negedge clk);
    o = sample(); e = q.pop_front(); nchk++;
    if (o !== e) begin nerr++; $display("FAIL reset_midop_load: got %h want %h", o, e); end
    @(posedge clk); #1;
    apply(cy(ln(0, 16, 0, 1), NOP, 1'b0, ex(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00)));
    @(negedge clk);
    o = sample(); e = q.pop_front(); nchk++;
    if (o !== e) begin nerr++; $display("FAIL reset_midop_blocked: got %h want %h", o, e); end
    nchk++;
    if (stall_cycles !== 16'(exp_sc)) begin nerr++; $display("FAIL reset_midop_pre_count: got %0d want %0d", stall_cycles, exp_sc); end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (issue !== 2'b01 || stall_d !== 1'b0) begin
      nerr++; $display("FAIL reset_midop_async_issue: got issue=%b stall_d=%b want issue=01 stall_d=0", issue, stall_d);
    end
    nchk++;
    if (stall_cycles !== 16'd0) begin nerr++; $display("FAIL reset_midop_async_count: got %0d want 0", stall_cycles); end
    exp_sc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply(cy(ln(0, 16, 0, 1), NOP, 1'b0, ex(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00)));
    @(negedge clk);
    o = sample(); e = q.pop_front(); nchk++;
    if (o !== e) begin nerr++; $display("FAIL reset_midop_after: got %h want %h", o, e); end
    @(posedge clk); #1;
    nchk++;
    if (stall_cycles !== 16'(exp_sc)) begin nerr++; $display("FAIL reset_midop_post_count: got %0d want %0d", stall_cycles, exp_sc); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_same_bundle_raw();
    test_independent();
    test_waw();
    test_flush();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
